// File: rtl/if_id_skid_stage_pkg.sv
// Shared core definitions for the fetch/decode boundary: default constants,
// fetch exception codes and the fetch beat record.
package core_pkg;
  localparam int          PC_W_DEF      = 32;
  localparam int          INST_W_DEF    = 32;
  localparam int          EXCP_W        = 4;
  localparam logic [31:0] NOP_INST_DEF  = 32'h0340_0000;  // andi r0,r0,0
  localparam logic [31:0] FILTER_PC_DEF = 32'h1bff_fffc;  // pre-reset fetch address

  localparam logic [EXCP_W-1:0] EXCP_NONE = 4'h0;
  localparam logic [EXCP_W-1:0] EXCP_ADEF = 4'h1;
  localparam logic [EXCP_W-1:0] EXCP_TLBR = 4'h2;
  localparam logic [EXCP_W-1:0] EXCP_PIF  = 4'h3;
  localparam logic [EXCP_W-1:0] EXCP_PPI  = 4'h4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic [EXCP_W-1:0]     excp;
  } fetch_beat;
endpackage

// File: rtl/if_id_skid_stage_if.sv
// IF->ID handshake bundle. slave is the stage's view, master is the fetch/decode side.
interface if_id_skid_stage_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int EXCP_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic [EXCP_W-1:0] in_excp;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [EXCP_W-1:0] out_excp;

  modport slave (
    input  in_valid, in_pc, in_inst, in_excp, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_excp
  );
  modport master (
    output in_valid, in_pc, in_inst, in_excp, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_excp
  );
endinterface

// File: rtl/if_id_skid_stage_skid.sv
// Generic 2-entry valid/ready skid buffer; all outputs come straight from flops.
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);
  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;
  logic         accept, pop;

  assign accept    = in_valid & ~skid_valid;
  assign pop       = main_valid & out_ready;
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {main_valid & skid_valid, main_valid ^ skid_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // data registers keep their contents so the visible PC holds
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (!skid_valid) begin
      if (pop && accept) begin
        main_data <= in_data;
      end else if (pop) begin
        main_valid <= 1'b0;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (pop) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID boundary: skid-buffered handshake with flush, pre-reset PC filtering,
// NOP substitution and exception-tag zeroing on an empty main entry.
module if_id_skid_stage
  import core_pkg::*;
#(
  parameter int                PC_W      = PC_W_DEF,
  parameter int                INST_W    = INST_W_DEF,
  parameter int                EXCP_W    = core_pkg::EXCP_W,
  parameter logic [INST_W-1:0] NOP_INST  = INST_W'(NOP_INST_DEF),
  parameter logic [PC_W-1:0]   FILTER_PC = PC_W'(FILTER_PC_DEF),
  parameter bit                FILTER_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  if_id_skid_stage_if.slave   bus,
  output logic [1:0]          occupancy
);
  localparam int W = PC_W + INST_W + EXCP_W;

  logic         drop_pc;
  logic         main_valid;
  logic [W-1:0] main_data;

  // A filtered beat still completes the handshake but never enters storage.
  assign drop_pc = FILTER_EN && (bus.in_pc == FILTER_PC);

  skid_buf2 #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid & ~drop_pc),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.in_pc, bus.in_inst, bus.in_excp}),
    .out_valid (main_valid),
    .out_ready (bus.out_ready),
    .out_data  (main_data),
    .occupancy (occupancy)
  );

  assign bus.out_valid = main_valid;
  assign bus.out_pc    = main_data[W-1 -: PC_W];
  assign bus.out_inst  = main_valid ? main_data[EXCP_W +: INST_W] : NOP_INST;
  assign bus.out_excp  = main_valid ? main_data[EXCP_W-1:0] : '0;
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed scenarios plus a randomized run against a
// queue-based model, on two instances (filter enabled and disabled).
module tb_if_id_skid_stage;
  import core_pkg::*;

  localparam logic [31:0] NOP  = 32'h0340_0000;
  localparam logic [31:0] FPC  = 32'h1bff_fffc;

  logic clk = 1'b0, rst, flush;
  logic in_valid, out_ready;
  logic [31:0] in_pc, in_inst;
  logic [3:0]  in_excp;
  logic [1:0]  occ0, occ1;

  int n_chk = 0, n_fail = 0;

  fetch_beat q0[$], q1[$];
  logic [31:0] lpc0 = '0, lpc1 = '0;

  always #5 clk = ~clk;

  if_id_skid_stage_if #(32, 32, 4) b0 ();
  if_id_skid_stage_if #(32, 32, 4) b1 ();

  assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
  assign b0.in_pc    = in_pc;     assign b1.in_pc    = in_pc;
  assign b0.in_inst  = in_inst;   assign b1.in_inst  = in_inst;
  assign b0.in_excp  = in_excp;   assign b1.in_excp  = in_excp;
  assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;

  if_id_skid_stage #(.FILTER_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .flush(flush), .bus(b0), .occupancy(occ0));
  if_id_skid_stage #(.FILTER_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(b1), .occupancy(occ1));

  // Reference: each instance is a FIFO of capacity 2; readiness is "fewer than
  // two held" as seen before the edge.
  task automatic cycle();
    bit rdy0, rdy1, pop0, pop1;
    fetch_beat bt;
    rdy0 = q0.size() < 2;
    rdy1 = q1.size() < 2;
    @(posedge clk);
    bt.pc = in_pc; bt.inst = in_inst; bt.excp = in_excp;
    if (rst) begin
      q0.delete(); q1.delete(); lpc0 = '0; lpc1 = '0;
    end else if (flush) begin
      q0.delete(); q1.delete();
    end else begin
      pop0 = q0.size() > 0 && out_ready;
      pop1 = q1.size() > 0 && out_ready;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (in_valid && rdy0 && in_pc != FPC) q0.push_back(bt);
      if (in_valid && rdy1) q1.push_back(bt);
    end
    if (q0.size() > 0) lpc0 = q0[0].pc;
    if (q1.size() > 0) lpc1 = q1[0].pc;
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; in_excp = 0; in_inst = $urandom;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; in_pc = 32'h1c00_0000; in_inst = 32'h1234_5678; in_excp = 4'h2; out_ready = 0;
    cycle(); cycle();
    n_chk++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", b0.out_valid); end
    n_chk++; if (b0.out_inst !== NOP) begin n_fail++; $display("FAIL reset_inst got %h want %h", b0.out_inst, NOP); end
    n_chk++; if (b0.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", b0.out_pc); end
    n_chk++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", b0.in_ready); end
    n_chk++; if (occ0 !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ0); end
    n_chk++; if (b1.out_valid !== 1'b0 || occ1 !== 2'd0) begin n_fail++; $display("FAIL reset_nofilt got v=%b occ=%0d want 0/0", b1.out_valid, occ1); end
    rst = 0; idle_inputs();
    cycle();
  endtask

  task automatic test_streaming();
    logic [31:0] pc, inst;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h1c00_0000 + 32'(4 * i); inst = $urandom;
      in_valid = 1; in_pc = pc; in_inst = inst; in_excp = 0;
      cycle();
      n_chk++; if (b0.out_valid !== 1'b1 || b0.out_pc !== pc) begin n_fail++; $display("FAIL stream_pc%0d got v=%b pc=%h want 1/%h", i, b0.out_valid, b0.out_pc, pc); end
      n_chk++; if (b0.out_inst !== inst) begin n_fail++; $display("FAIL stream_inst%0d got %h want %h", i, b0.out_inst, inst); end
      n_chk++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d got %b want 1", i, b0.in_ready); end
    end
    idle_inputs();
    cycle();
    n_chk++; if (b0.out_valid !== 1'b0 || b0.out_inst !== NOP) begin n_fail++; $display("FAIL stream_drain got v=%b inst=%h want 0/%h", b0.out_valid, b0.out_inst, NOP); end
    n_chk++; if (b0.out_pc !== 32'h1c00_0008) begin n_fail++; $display("FAIL stream_pc_hold got %h want 1c000008", b0.out_pc); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1; in_pc = 32'h1c00_0000; in_inst = 32'h0000_0001; in_excp = 0;
    cycle();
    n_chk++; if (occ0 !== 2'd1 || b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first got occ=%0d rdy=%b want 1/1", occ0, b0.in_ready); end
    in_pc = 32'h1c00_0004; in_inst = 32'h0000_0002;
    cycle();
    n_chk++; if (occ0 !== 2'd2 || b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b want 2/0", occ0, b0.in_ready); end
    n_chk++; if (b0.out_pc !== 32'h1c00_0000) begin n_fail++; $display("FAIL bp_head got %h want 1c000000", b0.out_pc); end
    idle_inputs(); out_ready = 1;
    cycle();
    n_chk++; if (b0.out_pc !== 32'h1c00_0004 || b0.out_inst !== 32'h2) begin n_fail++; $display("FAIL bp_second got pc=%h inst=%h want 1c000004/2", b0.out_pc, b0.out_inst); end
    n_chk++; if (b0.in_ready !== 1'b1 || occ0 !== 2'd1) begin n_fail++; $display("FAIL bp_reopen got rdy=%b occ=%0d want 1/1", b0.in_ready, occ0); end
    cycle();
    n_chk++; if (b0.out_valid !== 1'b0 || occ0 !== 2'd0) begin n_fail++; $display("FAIL bp_empty got v=%b occ=%0d want 0/0", b0.out_valid, occ0); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_pc = 32'h1c00_0020; in_inst = 32'hAAAA_0001; in_excp = 4'h3;
    cycle();
    in_pc = 32'h1c00_0024; in_inst = 32'hAAAA_0002;
    cycle();
    flush = 1; in_pc = 32'h1c00_0100; in_inst = 32'hBBBB_BBBB;
    cycle();
    idle_inputs();
    n_chk++; if (b0.out_valid !== 1'b0 || occ0 !== 2'd0) begin n_fail++; $display("FAIL flush_full got v=%b occ=%0d want 0/0", b0.out_valid, occ0); end
    n_chk++; if (b0.out_inst !== NOP || b0.out_excp !== 4'h0) begin n_fail++; $display("FAIL flush_nop got inst=%h excp=%h want %h/0", b0.out_inst, b0.out_excp, NOP); end
    n_chk++; if (b0.out_pc !== 32'h1c00_0020 || b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_pc got pc=%h rdy=%b want 1c000020/1", b0.out_pc, b0.in_ready); end
    // flush with one entry and a beat the stage is ready for: beat still discarded
    in_valid = 1; in_pc = 32'h1c00_0030;
    cycle();
    flush = 1; in_pc = 32'h1c00_0200;
    cycle();
    idle_inputs(); out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_chk++; if (b0.out_valid !== 1'b0 || b0.out_pc !== 32'h1c00_0030) begin n_fail++; $display("FAIL flush_discard%0d got v=%b pc=%h want 0/1c000030", i, b0.out_valid, b0.out_pc); end
    end
  endtask

  task automatic test_filter();
    logic [31:0] seen0[$], seen1[$];
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 2); in_pc = (i == 0) ? FPC : 32'h1c00_0000; in_inst = $urandom; in_excp = 0;
      cycle();
      if (b0.out_valid === 1'b1) seen0.push_back(b0.out_pc);
      if (b1.out_valid === 1'b1) seen1.push_back(b1.out_pc);
    end
    idle_inputs();
    n_chk++; if (seen0.size() !== 1 || (seen0.size() > 0 && seen0[0] !== 32'h1c00_0000)) begin n_fail++; $display("FAIL filter_on got %0d beats want 1 (1c000000)", seen0.size()); end
    n_chk++; if (seen1.size() !== 2) begin n_fail++; $display("FAIL filter_off_count got %0d want 2", seen1.size()); end
    else begin
      n_chk++; if (seen1[0] !== FPC || seen1[1] !== 32'h1c00_0000) begin n_fail++; $display("FAIL filter_off_order got %h,%h want %h,1c000000", seen1[0], seen1[1], FPC); end
    end
  endtask

  task automatic test_excp();
    out_ready = 1;
    in_valid = 1; in_pc = 32'h1c00_0010; in_inst = 32'h0280_0421; in_excp = EXCP_ADEF;
    cycle();
    n_chk++; if (b0.out_excp !== 4'h1 || b0.out_pc !== 32'h1c00_0010) begin n_fail++; $display("FAIL excp_tag got excp=%h pc=%h want 1/1c000010", b0.out_excp, b0.out_pc); end
    idle_inputs();
    cycle();
    n_chk++; if (b0.out_excp !== 4'h0 || b0.out_inst !== NOP) begin n_fail++; $display("FAIL excp_clear got excp=%h inst=%h want 0/%h", b0.out_excp, b0.out_inst, NOP); end
  endtask

  task automatic test_random();
    logic [31:0] e_inst, e_pc;
    logic [3:0]  e_excp;
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc     = ($urandom_range(0, 7) == 0) ? FPC : (32'h1c00_0000 | ($urandom & 32'h0000_fffc));
      in_inst   = $urandom;
      in_excp   = 4'($urandom);
      cycle();
      e_pc = lpc0; e_inst = (q0.size() > 0) ? q0[0].inst : NOP; e_excp = (q0.size() > 0) ? q0[0].excp : 4'h0;
      n_chk++; if (b0.out_valid !== (q0.size() > 0) || occ0 !== 2'(q0.size()) || b0.in_ready !== (q0.size() < 2)) begin
        n_fail++; $display("FAIL rand0_ctl@%0d got v=%b occ=%0d rdy=%b want occ=%0d", i, b0.out_valid, occ0, b0.in_ready, q0.size()); end
      n_chk++; if (b0.out_pc !== e_pc || b0.out_inst !== e_inst || b0.out_excp !== e_excp) begin
        n_fail++; $display("FAIL rand0_data@%0d got %h/%h/%h want %h/%h/%h", i, b0.out_pc, b0.out_inst, b0.out_excp, e_pc, e_inst, e_excp); end
      e_pc = lpc1; e_inst = (q1.size() > 0) ? q1[0].inst : NOP; e_excp = (q1.size() > 0) ? q1[0].excp : 4'h0;
      n_chk++; if (b1.out_valid !== (q1.size() > 0) || occ1 !== 2'(q1.size()) || b1.in_ready !== (q1.size() < 2)) begin
        n_fail++; $display("FAIL rand1_ctl@%0d got v=%b occ=%0d rdy=%b want occ=%0d", i, b1.out_valid, occ1, b1.in_ready, q1.size()); end
      n_chk++; if (b1.out_pc !== e_pc || b1.out_inst !== e_inst || b1.out_excp !== e_excp) begin
        n_fail++; $display("FAIL rand1_data@%0d got %h/%h/%h want %h/%h/%h", i, b1.out_pc, b1.out_inst, b1.out_excp, e_pc, e_inst, e_excp); end
      // a full skid with an empty main entry must never be observable
      n_chk++; if (occ0 === 2'd2 && b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_invariant@%0d got occ=2 v=%b want v=1", i, b0.out_valid); end
    end
    rst = 0; idle_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_filter();
    test_excp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
